// File: rtl/secure_lock_pkg.sv
// Shared types and defaults for the secure lock controller: state encoding,
// key width, timer/fail-counter widths and default parameter values.
package secure_lock_pkg;

    localparam int KEY_W   = 6;
    localparam int TIMER_W = 8;
    localparam int FAIL_W  = 4;

    localparam logic [KEY_W-1:0] DEFAULT_KEY         = 6'h2A;
    localparam int               DEFAULT_MAX_FAIL    = 3;
    localparam int               DEFAULT_LOCKOUT_CYC = 16;
    localparam int               DEFAULT_RELOCK_CYC  = 32;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_CHECK    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } lock_state_t;

    // Saturating increment: the fail count parks at the limit instead of wrapping.
    function automatic logic [FAIL_W-1:0] fail_sat_inc(input logic [FAIL_W-1:0] cnt,
                                                       input logic [FAIL_W-1:0] limit);
        return (cnt >= limit) ? limit : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable 8-bit down-counter with terminal-count flag; shared between the
// lockout hold-off and the auto-relock timeout.
module lock_timer
    import secure_lock_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               enable,
    output logic               done
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/secure_lock_ctrl.sv
// Key-checked lock controller driving a protected register's lock flop.
// Optional auto-relock from UNLOCKED is built when SECURE_LOCK_AUTO_RELOCK_EN is defined.
//
// state       | meaning
// ST_LOCKED   | writes blocked, accepting requests
// ST_CHECK    | request captured, decision issued on leaving this state
// ST_UNLOCKED | writes permitted, accepting requests (relock timer running if built)
// ST_LOCKOUT  | too many failed unlocks, requests refused until the timer expires
module secure_lock_ctrl
    import secure_lock_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY         = DEFAULT_KEY,
    parameter int               MAX_FAIL    = DEFAULT_MAX_FAIL,
    parameter int               LOCKOUT_CYC = DEFAULT_LOCKOUT_CYC,
    parameter int               RELOCK_CYC  = DEFAULT_RELOCK_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_unlock,
    input  logic [KEY_W-1:0] key_in,
    output logic             req_ready,
    output logic             resp_valid,
    output logic             resp_ok,
    output logic             lock_enable,
    output logic             lock_input,
    output logic             locked_out
);

    localparam logic [FAIL_W-1:0]  FAIL_LIMIT   = FAIL_W'(MAX_FAIL);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYC - 1);
    localparam logic [TIMER_W-1:0] RELOCK_LOAD  = TIMER_W'(RELOCK_CYC - 1);

    lock_state_t        state;
    logic               init_pend;
    logic [FAIL_W-1:0]  fail_cnt;
    logic               req_unlock_q;
    logic [KEY_W-1:0]   key_q;

    logic               accept;
    logic               key_match;
    logic [FAIL_W-1:0]  fail_next;
    logic               fail_hits_limit;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_enable;
    logic               timer_done;
    logic               relock_due;

    assign accept          = req_valid && req_ready;
    assign key_match       = (key_q == KEY);
    assign fail_next       = fail_sat_inc(fail_cnt, FAIL_LIMIT);
    assign fail_hits_limit = (fail_next == FAIL_LIMIT);

    // Timer is loaded on the decision edge so its count is already valid in the
    // first UNLOCKED or LOCKOUT cycle.
    assign timer_load   = (state == ST_CHECK) && req_unlock_q && (key_match || fail_hits_limit);
    assign timer_value  = key_match ? RELOCK_LOAD : LOCKOUT_LOAD;
    assign timer_enable = (state == ST_LOCKOUT) || (state == ST_UNLOCKED);

`ifdef SECURE_LOCK_AUTO_RELOCK_EN
    assign relock_due = timer_done;
`else
    assign relock_due = 1'b0;
`endif

    lock_timer u_lock_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .enable     (timer_enable),
        .done       (timer_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_LOCKED;
            init_pend    <= 1'b1;
            fail_cnt     <= '0;
            req_unlock_q <= 1'b0;
            key_q        <= '0;
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_ok      <= 1'b0;
            locked_out   <= 1'b0;
            lock_enable  <= 1'b1;
            lock_input   <= 1'b0;
        end else begin
            resp_valid  <= 1'b0;
            resp_ok     <= 1'b0;
            lock_enable <= 1'b0;
            lock_input  <= 1'b0;

            if (init_pend) begin
                // Second forced write of the lock flop before accepting anything.
                init_pend   <= 1'b0;
                lock_enable <= 1'b1;
                req_ready   <= 1'b0;
                locked_out  <= 1'b0;
            end else begin
                case (state)
                    ST_LOCKED: begin
                        if (accept) begin
                            state        <= ST_CHECK;
                            req_unlock_q <= req_unlock;
                            key_q        <= key_in;
                            req_ready    <= 1'b0;
                        end else begin
                            req_ready <= 1'b1;
                        end
                    end

                    ST_UNLOCKED: begin
                        if (accept) begin
                            state        <= ST_CHECK;
                            req_unlock_q <= req_unlock;
                            key_q        <= key_in;
                            req_ready    <= 1'b0;
                        end else if (relock_due) begin
                            state       <= ST_LOCKED;
                            lock_enable <= 1'b1;
                            req_ready   <= 1'b1;
                        end else begin
                            req_ready <= 1'b1;
                        end
                    end

                    ST_CHECK: begin
                        resp_valid  <= 1'b1;
                        lock_enable <= 1'b1;
                        if (!req_unlock_q) begin
                            state     <= ST_LOCKED;
                            resp_ok   <= 1'b1;
                            req_ready <= 1'b1;
                        end else if (key_match) begin
                            state      <= ST_UNLOCKED;
                            resp_ok    <= 1'b1;
                            lock_input <= 1'b1;
                            fail_cnt   <= '0;
                            req_ready  <= 1'b1;
                        end else begin
                            fail_cnt <= fail_next;
                            if (fail_hits_limit) begin
                                state      <= ST_LOCKOUT;
                                locked_out <= 1'b1;
                                req_ready  <= 1'b0;
                            end else begin
                                state     <= ST_LOCKED;
                                req_ready <= 1'b1;
                            end
                        end
                    end

                    ST_LOCKOUT: begin
                        if (timer_done) begin
                            state      <= ST_LOCKED;
                            fail_cnt   <= '0;
                            locked_out <= 1'b0;
                            req_ready  <= 1'b1;
                        end else begin
                            req_ready <= 1'b0;
                        end
                    end

                    default: begin
                        state     <= ST_LOCKED;
                        req_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_secure_lock_ctrl.sv
// Self-checking bench for secure_lock_ctrl: timestamp-based reference model
// compared every cycle, plus directed literal checks and random stimulus.
module tb_secure_lock_ctrl;

    localparam logic [5:0] KEY  = 6'h2A;
    localparam int         MAXF = 3;
    localparam int         LOCK = 16;
    localparam int         RELK = 32;
`ifdef SECURE_LOCK_AUTO_RELOCK_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_unlock;
    logic [5:0] key_in;
    logic       req_ready, resp_valid, resp_ok, lock_enable, lock_input, locked_out;

    int checks   = 0;
    int failures = 0;

    secure_lock_ctrl #(
        .KEY         (KEY),
        .MAX_FAIL    (MAXF),
        .LOCKOUT_CYC (LOCK),
        .RELOCK_CYC  (RELK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_unlock  (req_unlock),
        .key_in      (key_in),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_ok     (resp_ok),
        .lock_enable (lock_enable),
        .lock_input  (lock_input),
        .locked_out  (locked_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: modes plus absolute cycle timestamps for lockout end and relock.
    localparam int M_LOCKED = 0, M_UNLOCKED = 1, M_PENDING = 2, M_LOCKOUT = 3;
    int         m_mode = M_LOCKED;
    int         m_fails = 0;
    int         m_cyc = 0;
    int         m_lock_end = 0;
    int         m_relock_at = 0;
    bit         m_init = 1'b0;
    bit         m_armed = 1'b0;
    bit         m_pu;
    logic [5:0] m_pk;
    bit e_rv, e_ok, e_le, e_li, e_ready, e_lo;

    task automatic model_step();
        bit acc;
        m_cyc++;
        e_rv = 0; e_ok = 0; e_le = 0; e_li = 0;
        if (!reset) begin
            m_mode = M_LOCKED; m_fails = 0; m_init = 1;
            e_le = 1; e_ready = 0; e_lo = 0;
            return;
        end
        if (m_init) begin
            m_init = 0; e_le = 1; e_ready = 0; e_lo = 0;
            return;
        end
        acc = req_valid && e_ready;
        case (m_mode)
            M_LOCKED: if (acc) begin m_mode = M_PENDING; m_pu = req_unlock; m_pk = key_in; end
            M_UNLOCKED: begin
                if (acc) begin
                    m_mode = M_PENDING; m_pu = req_unlock; m_pk = key_in;
                end else if (AUTO && m_cyc == m_relock_at) begin
                    m_mode = M_LOCKED; e_le = 1;
                end
            end
            M_PENDING: begin
                e_rv = 1; e_le = 1;
                if (!m_pu) begin
                    e_ok = 1; m_mode = M_LOCKED;
                end else if (m_pk == KEY) begin
                    e_ok = 1; e_li = 1; m_fails = 0;
                    m_mode = M_UNLOCKED; m_relock_at = m_cyc + RELK;
                end else begin
                    m_fails = (m_fails + 1 > MAXF) ? MAXF : m_fails + 1;
                    if (m_fails == MAXF) begin
                        m_mode = M_LOCKOUT; m_lock_end = m_cyc + LOCK;
                    end else begin
                        m_mode = M_LOCKED;
                    end
                end
            end
            default: if (m_cyc == m_lock_end) begin m_mode = M_LOCKED; m_fails = 0; end
        endcase
        e_ready = (m_mode == M_LOCKED) || (m_mode == M_UNLOCKED);
        e_lo    = (m_mode == M_LOCKOUT);
    endtask

    initial begin : compare_proc
        forever begin
            @(negedge clk);
            if (m_armed) begin
                chk("m_resp_valid", resp_valid, e_rv);
                chk("m_resp_ok", resp_ok, e_ok);
                chk("m_lock_enable", lock_enable, e_le);
                chk("m_lock_input", lock_input, e_li);
                chk("m_req_ready", req_ready, e_ready);
                chk("m_locked_out", locked_out, e_lo);
            end
            model_step();
            m_armed = 1'b1;
        end
    end

    // Issue one request at posedge+1; returns in the decision cycle (accept + 2).
    task automatic issue(input bit unl, input logic [5:0] k);
        for (int w = 0; w < 200 && !req_ready; w++) begin
            @(posedge clk); #1;
        end
        if (!req_ready) chk("ready_timeout", req_ready, 1);
        req_valid = 1; req_unlock = unl; key_in = k;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
    endtask

    task automatic wait_lockout_end(input string name, input int exp_len);
        int n = 0;
        while (locked_out && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk(name, n, exp_len);
    endtask

    initial begin : stim
        int seg_prob;
        reset = 0; req_valid = 0; req_unlock = 0; key_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lock_enable", lock_enable, 1);
        chk("rst_lock_input", lock_input, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_locked_out", locked_out, 0);
        reset = 1;
        @(posedge clk); #1;
        chk("init_lock_enable", lock_enable, 1);
        chk("init_lock_input", lock_input, 0);
        chk("init_req_ready", req_ready, 0);
        @(posedge clk); #1;
        chk("post_init_ready", req_ready, 1);
        chk("post_init_le", lock_enable, 0);

        issue(1, 6'h2A);
        chk("unlock_rv", resp_valid, 1);
        chk("unlock_ok", resp_ok, 1);
        chk("unlock_le", lock_enable, 1);
        chk("unlock_li", lock_input, 1);

        issue(0, 6'h00);
        chk("lock_ok", resp_ok, 1);
        chk("lock_li", lock_input, 0);

        for (int i = 0; i < 3; i++) begin
            issue(1, 6'h15);
            chk("bad_rv", resp_valid, 1);
            chk("bad_ok", resp_ok, 0);
            chk("bad_le", lock_enable, 1);
            chk("bad_li", lock_input, 0);
        end
        chk("lockout_flag", locked_out, 1);
        chk("lockout_ready", req_ready, 0);
        wait_lockout_end("lockout_len", 16);
        chk("after_lockout_ready", req_ready, 1);
        chk("after_lockout_le", lock_enable, 0);
        issue(1, 6'h2A);
        chk("after_lockout_unlock_ok", resp_ok, 1);

        issue(1, 6'h3F);
        chk("relock_bad_ok", resp_ok, 0);
        chk("relock_bad_le", lock_enable, 1);
        chk("relock_bad_li", lock_input, 0);
        issue(1, 6'h01);
        chk("fail2_no_lockout", locked_out, 0);
        issue(1, 6'h02);
        chk("fail3_lockout", locked_out, 1);
        wait_lockout_end("lockout_len2", 16);

        issue(1, 6'h2A);
        repeat (RELK) @(posedge clk);
        #1;
        chk("idle_relock_le", lock_enable, AUTO);
        chk("idle_relock_li", lock_input, 0);
        chk("idle_relock_rv", resp_valid, 0);

        issue(1, 6'h2A);
        repeat (RELK - 1) @(posedge clk);
        #1;
        req_valid = 1; req_unlock = 0; key_in = 6'h2A;
        @(posedge clk); #1;
        req_valid = 0;
        chk("expiry_no_pulse", lock_enable, 0);
        @(posedge clk); #1;
        chk("expiry_rv", resp_valid, 1);
        chk("expiry_ok", resp_ok, 1);
        chk("expiry_le", lock_enable, 1);
        chk("expiry_li", lock_input, 0);

        @(posedge clk); #1;
        req_valid = 1; req_unlock = 1; key_in = 6'h2A;
        @(posedge clk); #1;
        req_valid = 0;
        reset = 0;
        @(posedge clk); #1;
        chk("chk_rst_rv", resp_valid, 0);
        chk("chk_rst_ok", resp_ok, 0);
        chk("chk_rst_le", lock_enable, 1);
        chk("chk_rst_li", lock_input, 0);
        chk("chk_rst_ready", req_ready, 0);
        reset = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("chk_rst_ready_back", req_ready, 1);

        seg_prob = 50;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if (i % 250 == 0) seg_prob = ($urandom_range(0, 1) == 0) ? 50 : 3;
            reset      = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            req_valid  = ($urandom_range(0, 99) < seg_prob);
            req_unlock = ($urandom_range(0, 9) < 7);
            key_in     = ($urandom_range(0, 1) == 0) ? KEY : 6'($urandom_range(0, 63));
        end
        reset = 1; req_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
